timer_irq: RTL

- Memory-mapped programmable countdown timer; the interrupt initiator whose `irq` output drives one bit of the CP0 `hwirq[5:0]` input.
- Software programs it through three word registers: CTRL, PRESET and COUNT.
- When the count expires it raises `irq`. The CPU takes the interrupt via CP0 and clears it with a store to CTRL.
- Sits on the bridge/device side of the datapath, next to other peripherals.

---
 rtl/timer_irq_if.sv | 18 +
 rtl/timer_irq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/timer_irq_if.sv
// Register-bus and interrupt bundle between the CPU bridge and the countdown timer.
interface timer_irq_if;
  logic [1:0]  addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic        irq;

  modport master (
    output addr, write_enable, write_data,
    input  read_result, irq
  );

  modport slave (
    input  addr, write_enable, write_data,
    output read_result, irq
  );
endinterface

// File: rtl/timer_irq.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) raising a level irq to CP0 on expiry.
// Optional TIMER_PRESCALE_EN: count steps once every PRESCALE cycles instead of every cycle.
module timer_irq #(
  parameter int          PRESCALE     = 1,
  parameter logic [31:0] RESET_PRESET = 32'd0
) (
  input logic        clk,
  input logic        rst,
  timer_irq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state, state_nxt;
  logic        en, en_nxt;
  logic [1:0]  mode, mode_nxt;
  logic        im, im_nxt;
  logic [31:0] preset, preset_nxt;
  logic [31:0] count, count_nxt;
  logic        pending, pending_nxt;
  logic        wr_ctrl, wr_preset;
  logic        step;

`ifdef TIMER_PRESCALE_EN
  logic [31:0] presc, presc_nxt;
  assign step = (presc == 32'(PRESCALE - 1));
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign step = 1'b1;
`endif

  assign wr_ctrl   = bus.write_enable && (bus.addr == 2'd0);
  assign wr_preset = bus.write_enable && (bus.addr == 2'd1);

  always_comb begin
    state_nxt   = state;
    en_nxt      = en;
    mode_nxt    = mode;
    im_nxt      = im;
    preset_nxt  = preset;
    count_nxt   = count;
    pending_nxt = pending;
`ifdef TIMER_PRESCALE_EN
    presc_nxt   = presc;
`endif
    // Register writes pre-empt the FSM, so a write landing on the expiry cycle suppresses it.
    if (wr_ctrl) begin
      en_nxt      = bus.write_data[0];
      mode_nxt    = bus.write_data[2:1];
      im_nxt      = bus.write_data[3];
      pending_nxt = 1'b0;
      state_nxt   = bus.write_data[0] ? LOAD : IDLE;
`ifdef TIMER_PRESCALE_EN
      presc_nxt   = '0;
`endif
    end else if (wr_preset) begin
      preset_nxt = bus.write_data;
      if (en) state_nxt = LOAD;
    end else begin
      case (state)
        IDLE: if (en) state_nxt = LOAD;
        LOAD: begin
          count_nxt = preset;
          state_nxt = CNT;
`ifdef TIMER_PRESCALE_EN
          presc_nxt = '0;
`endif
        end
        CNT: begin
          if (!en) begin
            state_nxt = IDLE;
          end else begin
`ifdef TIMER_PRESCALE_EN
            presc_nxt = step ? '0 : presc + 32'd1;
`endif
            if (step) begin
              if (count > 32'd1) begin
                count_nxt = count - 32'd1;
              end else begin
                count_nxt   = '0;
                pending_nxt = 1'b1;
                state_nxt   = INT;
              end
            end
          end
        end
        INT: begin
          // Only MODE 1 reloads; MODE 0, 2 and 3 all behave as one-shot.
          if (mode == 2'd1) begin
            pending_nxt = 1'b0;
            state_nxt   = LOAD;
          end else begin
            en_nxt    = 1'b0;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      en      <= 1'b0;
      mode    <= 2'd0;
      im      <= 1'b0;
      preset  <= RESET_PRESET;
      count   <= '0;
      pending <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      presc   <= '0;
`endif
    end else begin
      state   <= state_nxt;
      en      <= en_nxt;
      mode    <= mode_nxt;
      im      <= im_nxt;
      preset  <= preset_nxt;
      count   <= count_nxt;
      pending <= pending_nxt;
`ifdef TIMER_PRESCALE_EN
      presc   <= presc_nxt;
`endif
    end
  end

  always_comb begin
    bus.read_result = '0;
    case (bus.addr)
      2'd0:    bus.read_result = {28'b0, im, mode, en};
      2'd1:    bus.read_result = preset;
      2'd2:    bus.read_result = count;
      default: bus.read_result = '0;
    endcase
  end

  assign bus.irq = im & pending;

endmodule
